// File: rtl/matrix_ram_mp.sv
// matrix_ram_mp: multi-ported N_ROWS x N_COLS bit matrix, row/column addressable, with bulk-clear engine.
// Optional write-to-read forwarding is enabled by defining MATRIX_RAM_MP_BYPASS_EN.
module matrix_ram_mp #(
    parameter int N_ROWS             = 8,
    parameter int N_COLS             = 8,
    parameter int N_RD_PORTS         = 2,
    parameter int N_WR_PORTS         = 2,
    parameter int CLR_ROWS_PER_CYCLE = 2,
    localparam int RA_W              = $clog2(N_ROWS),
    localparam int CA_W              = $clog2(N_COLS)
) (
    input  logic                                  clk,
    input  logic                                  rst_aH,
    input  logic [N_RD_PORTS-1:0][RA_W-1:0]       row_rd_addr,
    output logic [N_RD_PORTS-1:0][N_COLS-1:0]     row_rd_data,
    input  logic [N_RD_PORTS-1:0][CA_W-1:0]       col_rd_addr,
    output logic [N_RD_PORTS-1:0][N_ROWS-1:0]     col_rd_data,
    input  logic [N_WR_PORTS-1:0]                 row_wr_en,
    input  logic [N_WR_PORTS-1:0][RA_W-1:0]       row_wr_addr,
    input  logic [N_WR_PORTS-1:0][N_COLS-1:0]     row_wr_data,
    input  logic [N_WR_PORTS-1:0]                 col_wr_en,
    input  logic [N_WR_PORTS-1:0][CA_W-1:0]       col_wr_addr,
    input  logic [N_WR_PORTS-1:0][N_ROWS-1:0]     col_wr_data,
    output logic [N_ROWS-1:0]                     row_nonzero,
    input  logic                                  clr_req,
    output logic                                  clr_busy,
    output logic                                  clr_done,
    output logic [N_ROWS-1:0][N_COLS-1:0]         cur_state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [N_ROWS-1:0][N_COLS-1:0] mat;
    logic [N_ROWS-1:0][N_COLS-1:0] mat_nxt;
    logic [N_ROWS-1:0][N_COLS-1:0] rd_src;
    logic [1:0]                    state;
    logic [RA_W:0]                 clr_cnt;
    logic                          clr_last;

    assign clr_busy  = (state != ST_IDLE);
    assign clr_done  = (state == ST_DONE);
    assign clr_last  = (32'(clr_cnt) == N_ROWS - CLR_ROWS_PER_CYCLE);
    assign cur_state = mat;

    // Column writes are applied after row writes so they win at intersections;
    // later ports overwrite earlier ones on equal addresses.
    always_comb begin
        mat_nxt = mat;
        if (!clr_busy) begin
            for (int unsigned p = 0; p < N_WR_PORTS; p++) begin
                if (row_wr_en[p] && (32'(row_wr_addr[p]) < N_ROWS))
                    mat_nxt[row_wr_addr[p]] = row_wr_data[p];
            end
            for (int unsigned p = 0; p < N_WR_PORTS; p++) begin
                if (col_wr_en[p] && (32'(col_wr_addr[p]) < N_COLS)) begin
                    for (int unsigned r = 0; r < N_ROWS; r++)
                        mat_nxt[r][col_wr_addr[p]] = col_wr_data[p][r];
                end
            end
        end
        if (state == ST_CLEAR) begin
            for (int unsigned r = 0; r < N_ROWS; r++) begin
                if ((r >= 32'(clr_cnt)) && (r < 32'(clr_cnt) + CLR_ROWS_PER_CYCLE))
                    mat_nxt[r] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_aH) begin
        if (rst_aH) begin
            mat     <= '0;
            state   <= ST_IDLE;
            clr_cnt <= '0;
        end else begin
            mat <= mat_nxt;
            case (state)
                ST_IDLE: begin
                    if (clr_req) begin
                        state   <= ST_CLEAR;
                        clr_cnt <= '0;
                    end
                end
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + (RA_W+1)'(CLR_ROWS_PER_CYCLE);
                    if (clr_last)
                        state <= ST_DONE;
                end
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

`ifdef MATRIX_RAM_MP_BYPASS_EN
    assign rd_src = mat_nxt;
`else
    assign rd_src = mat;
`endif

    // Reads are forced to zero during reset so forwarded next-state never leaks out.
    always_comb begin
        row_rd_data = '0;
        col_rd_data = '0;
        if (!rst_aH) begin
            for (int unsigned p = 0; p < N_RD_PORTS; p++) begin
                if (32'(row_rd_addr[p]) < N_ROWS)
                    row_rd_data[p] = rd_src[row_rd_addr[p]];
                if (32'(col_rd_addr[p]) < N_COLS) begin
                    for (int unsigned r = 0; r < N_ROWS; r++)
                        col_rd_data[p][r] = rd_src[r][col_rd_addr[p]];
                end
            end
        end
    end

    always_comb begin
        row_nonzero = '0;
        for (int unsigned r = 0; r < N_ROWS; r++)
            row_nonzero[r] = |mat[r];
    end

endmodule
